// File: rtl/calc_input_sequencer.sv
// Input sequencer for the 4-bit ALU calculator: collects A, B and the
// operation from switches on successive enter pulses, drives them to the
// ALU, waits a fixed settle time, then captures and holds the result.

package calc_input_sequencer_pkg;

  typedef enum logic [2:0] {
    GET_A  = 3'd0,
    GET_B  = 3'd1,
    GET_OP = 3'd2,
    EXEC   = 3'd3,
    SHOW   = 3'd4
  } state_e;

endpackage

module calc_input_sequencer
  import calc_input_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH          = 4,
  parameter int unsigned RESULT_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  input  logic             op_type,
  input  logic [1:0]       op_sel,
  input  logic             enter,
  input  logic             clear,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_type,
  output logic [1:0]       alu_select,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_overflow,
  output logic [WIDTH-1:0] result_q,
  output logic             ovf_q,
  output logic             done,
  output logic             busy,
  output logic [2:0]       state_o
);

  // Count value seen during the final EXEC cycle; capture happens on the
  // edge that ends it.
  localparam logic [3:0] LAST_CNT = 4'(RESULT_LATENCY - 1);

  state_e           state_q,      state_d;
  logic [WIDTH-1:0] alu_a_q,      alu_a_d;
  logic [WIDTH-1:0] alu_b_q,      alu_b_d;
  logic             alu_type_q,   alu_type_d;
  logic [1:0]       alu_select_q, alu_select_d;
  logic [WIDTH-1:0] result_d;
  logic             ovf_d;
  logic             done_q,       done_d;
  logic [3:0]       cnt_q,        cnt_d;

  // Next-state and register-update logic; clear overrides every state.
  always_comb begin
    state_d      = state_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_type_d   = alu_type_q;
    alu_select_d = alu_select_q;
    result_d     = result_q;
    ovf_d        = ovf_q;
    cnt_d        = cnt_q;
    done_d       = 1'b0;

    if (clear) begin
      state_d      = GET_A;
      alu_a_d      = '0;
      alu_b_d      = '0;
      alu_type_d   = 1'b0;
      alu_select_d = '0;
      result_d     = '0;
      ovf_d        = 1'b0;
      cnt_d        = '0;
    end else begin
      case (state_q)
        GET_A: begin
          if (enter) begin
            alu_a_d = sw;
            state_d = GET_B;
          end
        end
        GET_B: begin
          if (enter) begin
            alu_b_d = sw;
            state_d = GET_OP;
          end
        end
        GET_OP: begin
          if (enter) begin
            alu_type_d   = op_type;
            alu_select_d = op_sel;
            cnt_d        = '0;
            state_d      = EXEC;
          end
        end
        EXEC: begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == LAST_CNT) begin
            result_d = alu_result;
            ovf_d    = alu_overflow;
            done_d   = 1'b1;
            state_d  = SHOW;
          end
        end
        SHOW: begin
          // Chaining: the held result becomes operand A, switches ignored.
          if (enter) begin
            alu_a_d = result_q;
            state_d = GET_B;
          end
        end
        default: state_d = GET_A;
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= GET_A;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_type_q   <= 1'b0;
      alu_select_q <= '0;
      result_q     <= '0;
      ovf_q        <= 1'b0;
      done_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_type_q   <= alu_type_d;
      alu_select_q <= alu_select_d;
      result_q     <= result_d;
      ovf_q        <= ovf_d;
      done_q       <= done_d;
      cnt_q        <= cnt_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_type   = alu_type_q;
  assign alu_select = alu_select_q;
  assign done       = done_q;
  assign busy       = (state_q == EXEC);
  assign state_o    = state_q;

endmodule

// File: tb/tb_calc_input_sequencer.sv
// Directed bench for calc_input_sequencer with a behavioural 4-bit ALU
// connected to the operand outputs.

module tb_calc_input_sequencer;

  localparam int unsigned LAT = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sw;
  logic       op_type;
  logic [1:0] op_sel;
  logic       enter;
  logic       clear;
  logic [3:0] alu_a, alu_b, alu_result, result_q;
  logic       alu_type, alu_overflow, ovf_q, done, busy;
  logic [1:0] alu_select;
  logic [2:0] state_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  calc_input_sequencer #(.WIDTH(4), .RESULT_LATENCY(LAT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sw           (sw),
    .op_type      (op_type),
    .op_sel       (op_sel),
    .enter        (enter),
    .clear        (clear),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_type     (alu_type),
    .alu_select   (alu_select),
    .alu_result   (alu_result),
    .alu_overflow (alu_overflow),
    .result_q     (result_q),
    .ovf_q        (ovf_q),
    .done         (done),
    .busy         (busy),
    .state_o      (state_o)
  );

  // Behavioural ALU: {carry, result}
  function automatic logic [4:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                           input logic t, input logic [1:0] s);
    logic [7:0] p;
    p = {4'd0, a} * {4'd0, b};
    if (!t) begin
      case (s)
        2'b00:   return {1'b0, a} + {1'b0, b};
        2'b01:   return {1'b0, a} + {1'b0, ~b} + 5'd1;
        2'b10:   return {1'b0, p[3:0]};
        default: return {a[3], a[2:0], 1'b0};
      endcase
    end else begin
      case (s)
        2'b00:   return {1'b0, a & b};
        2'b01:   return {1'b0, a | b};
        2'b10:   return {1'b0, ~a};
        default: return {1'b0, a ^ b};
      endcase
    end
  endfunction

  always_comb {alu_overflow, alu_result} = alu_model(alu_a, alu_b, alu_type, alu_select);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] v);
    sw    = v;
    enter = 1'b1;
    tick();
    enter = 1'b0;
  endtask

  // Enter the op from GET_OP, then follow EXEC to SHOW checking done timing.
  task automatic finish_op(input string tag, input logic t, input logic [1:0] s,
                           input logic [3:0] exp_r, input logic exp_o);
    op_type = t;
    op_sel  = s;
    enter   = 1'b1;
    tick();
    enter   = 1'b0;
    check({tag, ":busy"}, 32'(busy), 32'd1);
    check({tag, ":exec_state"}, 32'(state_o), 32'd3);
    for (int i = 1; i < int'(LAT); i++) begin
      tick();
      check({tag, ":early_done"}, 32'(done), 32'd0);
    end
    tick();
    check({tag, ":done"}, 32'(done), 32'd1);
    check({tag, ":show_state"}, 32'(state_o), 32'd4);
    check({tag, ":result"}, 32'(result_q), 32'(exp_r));
    check({tag, ":ovf"}, 32'(ovf_q), 32'(exp_o));
    tick();
    check({tag, ":done_drop"}, 32'(done), 32'd0);
    check({tag, ":result_hold"}, 32'(result_q), 32'(exp_r));
  endtask

  task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic t, input logic [1:0] s,
                        input logic [3:0] exp_r, input logic exp_o);
    press(a);
    press(b);
    finish_op(tag, t, s, exp_r, exp_o);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; sw = '0; op_type = 1'b0; op_sel = '0; enter = 1'b0; clear = 1'b0;
    #12;
    check("rst:state", 32'(state_o), 32'd0);
    check("rst:busy", 32'(busy), 32'd0);
    check("rst:result", 32'(result_q), 32'd0);
    check("rst:done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    run_op("add38", 4'd3, 4'd5, 1'b0, 2'b00, 4'd8, 1'b0);

    do_clear();
    check("clr_show:state", 32'(state_o), 32'd0);
    check("clr_show:result", 32'(result_q), 32'd0);

    run_op("add_ovf", 4'd9, 4'd9, 1'b0, 2'b00, 4'd2, 1'b1);
    do_clear();
    run_op("sub", 4'd3, 4'd5, 1'b0, 2'b01, 4'hE, 1'b0);
    do_clear();
    run_op("mul", 4'd5, 4'd4, 1'b0, 2'b10, 4'd4, 1'b0);
    do_clear();
    run_op("xor", 4'hA, 4'h6, 1'b1, 2'b11, 4'hC, 1'b0);
    do_clear();

    // Chaining: 3+5=8, then 8+1=9 with sw ignored in SHOW
    run_op("chain1", 4'd3, 4'd5, 1'b0, 2'b00, 4'd8, 1'b0);
    press(4'hF);
    check("chain:state", 32'(state_o), 32'd1);
    check("chain:alu_a", 32'(alu_a), 32'd8);
    press(4'd1);
    finish_op("chain2", 1'b0, 2'b00, 4'd9, 1'b0);
    do_clear();

    // clear with enter in GET_OP
    press(4'd7);
    press(4'd2);
    op_type = 1'b1; op_sel = 2'b11;
    enter = 1'b1; clear = 1'b1;
    tick();
    enter = 1'b0; clear = 1'b0;
    check("clr_op:state", 32'(state_o), 32'd0);
    check("clr_op:alu_a", 32'(alu_a), 32'd0);
    check("clr_op:alu_b", 32'(alu_b), 32'd0);
    check("clr_op:type", 32'(alu_type), 32'd0);
    for (int i = 0; i < int'(LAT) + 1; i++) begin
      tick();
      check("clr_op:no_done", 32'(done), 32'd0);
    end

    // clear during EXEC: no capture, no done
    press(4'd6);
    press(4'd6);
    op_type = 1'b0; op_sel = 2'b00;
    enter = 1'b1;
    tick();
    enter = 1'b0;
    do_clear();
    check("clr_exec:state", 32'(state_o), 32'd0);
    for (int i = 0; i < int'(LAT) + 1; i++) begin
      tick();
      check("clr_exec:no_done", 32'(done), 32'd0);
    end
    check("clr_exec:result", 32'(result_q), 32'd0);

    // Asynchronous reset mid-EXEC
    press(4'd3);
    press(4'd5);
    op_type = 1'b1; op_sel = 2'b01;
    enter = 1'b1;
    tick();
    enter = 1'b0;
    tick();
    check("arst:pre_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst:state", 32'(state_o), 32'd0);
    check("arst:busy", 32'(busy), 32'd0);
    check("arst:alu_a", 32'(alu_a), 32'd0);
    check("arst:alu_b", 32'(alu_b), 32'd0);
    check("arst:type", 32'(alu_type), 32'd0);
    check("arst:sel", 32'(alu_select), 32'd0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < int'(LAT) + 1; i++) begin
      tick();
      check("arst:no_done", 32'(done), 32'd0);
    end
    check("arst:result", 32'(result_q), 32'd0);
    check("arst:ovf", 32'(ovf_q), 32'd0);

    // enter held for two cycles advances two states
    sw = 4'd4;
    enter = 1'b1;
    tick();
    tick();
    enter = 1'b0;
    check("hold:state", 32'(state_o), 32'd2);
    check("hold:alu_b", 32'(alu_b), 32'd4);
    do_clear();

    // Illegal state recovery
    force dut.state_q = calc_input_sequencer_pkg::state_e'(3'd6);
    #1;
    check("illegal:forced", 32'(state_o), 32'd6);
    release dut.state_q;
    tick();
    check("illegal:recover", 32'(state_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
